// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared state, ALU, command and condition-code definitions for the multicycle control unit
package cu_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_MI = 4'b0100;
    localparam logic [3:0] CC_PL = 4'b0101;
    localparam logic [3:0] CC_VS = 4'b0110;
    localparam logic [3:0] CC_VC = 4'b0111;
    localparam logic [3:0] CC_HI = 4'b1000;
    localparam logic [3:0] CC_LS = 4'b1001;
    localparam logic [3:0] CC_GE = 4'b1010;
    localparam logic [3:0] CC_LT = 4'b1011;
    localparam logic [3:0] CC_GT = 4'b1100;
    localparam logic [3:0] CC_LE = 4'b1101;
    localparam logic [3:0] CC_AL = 4'b1110;

    // Unlisted command codes fall back to ADD; EOR degrades to AND on a 2-bit ALU.
    function automatic logic [2:0] alu_decode(input logic [3:0] cmd, input logic eor_en);
        case (cmd)
            CMD_ADD:          return ALU_ADD;
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            CMD_EOR:          return eor_en ? ALU_EOR : ALU_AND;
            default:          return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational condition-field evaluation against stored NZCV
module cond_check
    import cu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign {n, z, c, v} = nzcv;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            CC_EQ:   cond_ex = z;
            CC_NE:   cond_ex = ~z;
            CC_CS:   cond_ex = c;
            CC_CC:   cond_ex = ~c;
            CC_MI:   cond_ex = n;
            CC_PL:   cond_ex = ~n;
            CC_VS:   cond_ex = v;
            CC_VC:   cond_ex = ~v;
            CC_HI:   cond_ex = c & ~z;
            CC_LS:   cond_ex = ~c | z;
            CC_GE:   cond_ex = (n == v);
            CC_LT:   cond_ex = (n != v);
            CC_GT:   cond_ex = ~z & (n == v);
            CC_LE:   cond_ex = z | (n != v);
            CC_AL:   cond_ex = 1'b1;
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle instruction sequencer with bounded memory waits
// Defining CU_RETIRE_CNT_EN adds the InstrCount retire counter output.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int ALU_CTRL_W   = 2,
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            Cond,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rd,
    input  logic [3:0]            Flags,
    input  logic                  MemReady,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic [1:0]            ResultSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic                  RegWrite,
    output logic                  MemTimeout
`ifdef CU_RETIRE_CNT_EN
    ,
    output logic [31:0]           InstrCount
`endif
);

    localparam bit                WAIT_EN = (MEM_WAIT_MAX > 0);
    localparam int                CNT_W   = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MEM_WAIT_MAX);

    state_t           state, next_state;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             cond_ex;
    logic             waiting, timeout;
    logic [3:0]       cmd;
    logic             s_bit, is_cmp, in_exec;
    logic             nz_en, cv_en;
    logic [2:0]       alu_sel;

    assign cmd     = Funct[4:1];
    assign s_bit   = Funct[0];
    assign is_cmp  = (cmd == CMD_CMP);
    assign in_exec = (state == EXECR) || (state == EXECI);
    assign nz_en   = s_bit | is_cmp;
    assign cv_en   = is_cmp | (s_bit & ((cmd == CMD_ADD) | (cmd == CMD_SUB)));

    assign ImmSrc = Op;
    assign RegSrc = {Op == OP_MEM, Op == OP_BR};

    cond_check u_cond_check (
        .cond    (Cond),
        .nzcv    (flags_q),
        .cond_ex (cond_ex)
    );

    // A stalled access may sit at the limit with MemReady high: ready takes priority.
    assign waiting = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !MemReady;
    assign timeout = WAIT_EN && waiting && (wait_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (WAIT_EN && waiting && !timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else if (in_exec) begin
            if (nz_en) flags_q[3:2] <= Flags[3:2];
            if (cv_en) flags_q[1:0] <= Flags[1:0];
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = MemReady ? DECODE : FETCH;
            DECODE: begin
                if (!cond_ex) begin
                    next_state = FETCH;
                end else begin
                    case (Op)
                        OP_MEM:  next_state = MEMADR;
                        OP_DP:   next_state = Funct[5] ? EXECI : EXECR;
                        OP_BR:   next_state = BRANCH;
                        default: next_state = FETCH;
                    endcase
                end
            end
            MEMADR: next_state = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  next_state = MemReady ? MEMWB : (timeout ? FETCH : MEMRD);
            MEMWB:  next_state = FETCH;
            MEMWR:  next_state = (MemReady || timeout) ? FETCH : MEMWR;
            EXECR:  next_state = ALUWB;
            EXECI:  next_state = ALUWB;
            ALUWB:  next_state = FETCH;
            BRANCH: next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        alu_sel   = ALU_ADD;
        case (state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                PCWrite   = (Rd == 4'd15);
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = ~timeout;
            end
            EXECR: alu_sel = alu_decode(cmd, ALU_CTRL_W >= 3);
            EXECI: begin
                ALUSrcB = 2'b01;
                alu_sel = alu_decode(cmd, ALU_CTRL_W >= 3);
            end
            ALUWB: begin
                RegWrite = ~is_cmp;
                PCWrite  = ~is_cmp & (Rd == 4'd15);
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides combinationally so a pending write strobe drops immediately.
        if (rst) begin
            PCWrite   = 1'b0;
            AdrSrc    = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            ResultSrc = 2'b10;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            alu_sel   = ALU_ADD;
        end
    end

    assign ALUControl = ALU_CTRL_W'(alu_sel);
    assign MemTimeout = timeout & ~rst;

`ifdef CU_RETIRE_CNT_EN
    logic [31:0] retire_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (next_state == FETCH && state != FETCH) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign InstrCount = retire_cnt;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench with an instruction-level reference model
module tb_multicycle_control_unit;

    localparam int WAIT_MAX = 3;
    localparam int ACW      = 3;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] res;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic [1:0] imm;
        logic [1:0] regsrc;
        logic       rw;
        logic       to;
    } outs_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     cond;
    logic [1:0]     op;
    logic [5:0]     funct;
    logic [3:0]     rd;
    logic [3:0]     flags;
    logic           mem_ready;
    logic           pc_write, adr_src, mem_write, ir_write, reg_write, mem_timeout, alu_src_a;
    logic [1:0]     result_src, alu_src_b, imm_src, reg_src;
    logic [ACW-1:0] alu_control;
`ifdef CU_RETIRE_CNT_EN
    logic [31:0]    instr_count;
`endif

    outs_t          obs;
    outs_t          exp_q[$];
    logic           rdy[64];
    logic [3:0]     mflags;
    int unsigned    mcount;
    int             checks = 0;
    int             errors = 0;
    int             n_instr = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_CTRL_W(ACW), .MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .Cond       (cond),
        .Op         (op),
        .Funct      (funct),
        .Rd         (rd),
        .Flags      (flags),
        .MemReady   (mem_ready),
        .PCWrite    (pc_write),
        .AdrSrc     (adr_src),
        .MemWrite   (mem_write),
        .IRWrite    (ir_write),
        .ResultSrc  (result_src),
        .ALUSrcA    (alu_src_a),
        .ALUSrcB    (alu_src_b),
        .ALUControl (alu_control),
        .ImmSrc     (imm_src),
        .RegSrc     (reg_src),
        .RegWrite   (reg_write),
        .MemTimeout (mem_timeout)
`ifdef CU_RETIRE_CNT_EN
        ,
        .InstrCount (instr_count)
`endif
    );

    assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                  3'(alu_control), imm_src, reg_src, reg_write, mem_timeout};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 3'd0;
            4'b0010: return 3'd1;
            4'b1010: return 3'd1;
            4'b0000: return 3'd2;
            4'b1100: return 3'd3;
            4'b0001: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic outs_t blank(input logic [1:0] iop);
        outs_t r;
        r        = '0;
        r.imm    = iop;
        r.regsrc = {iop == 2'b01, iop == 2'b10};
        return r;
    endfunction

    function automatic outs_t pc_sel(input logic [1:0] iop);
        outs_t r;
        r      = blank(iop);
        r.srca = 1'b1;
        r.srcb = 2'b10;
        r.res  = 2'b10;
        return r;
    endfunction

    // Builds the expected per-cycle output trace of one instruction from the MemReady script rdy[].
    task automatic build(input logic [3:0] ic, input logic [1:0] iop, input logic [5:0] ifn,
                         input logic [3:0] ird, input logic [3:0] ifl);
        outs_t      r;
        int         w;
        logic [3:0] cmd;
        exp_q.delete();
        w = 0;
        while (exp_q.size() < 64) begin
            r = pc_sel(iop);
            if (rdy[exp_q.size()]) begin
                r.pcw = 1'b1;
                r.irw = 1'b1;
                exp_q.push_back(r);
                break;
            end
            if (WAIT_MAX > 0 && w == WAIT_MAX) begin
                r.to = 1'b1;
                w    = 0;
            end else begin
                w++;
            end
            exp_q.push_back(r);
        end
        exp_q.push_back(pc_sel(iop));
        if (!cond_holds(ic, mflags) || iop == 2'b11) return;
        cmd = ifn[4:1];
        if (iop == 2'b00) begin
            r      = blank(iop);
            r.srcb = ifn[5] ? 2'b01 : 2'b00;
            r.alu  = alu_of(cmd);
            exp_q.push_back(r);
            if (cmd == 4'b1010) begin
                mflags = ifl;
            end else if (ifn[0]) begin
                mflags[3:2] = ifl[3:2];
                if (cmd == 4'b0100 || cmd == 4'b0010) mflags[1:0] = ifl[1:0];
            end
            r     = blank(iop);
            r.rw  = (cmd != 4'b1010);
            r.pcw = (cmd != 4'b1010) && (ird == 4'd15);
            exp_q.push_back(r);
        end else if (iop == 2'b10) begin
            r      = blank(iop);
            r.srcb = 2'b01;
            r.res  = 2'b10;
            r.pcw  = 1'b1;
            exp_q.push_back(r);
        end else begin
            r      = blank(iop);
            r.srcb = 2'b01;
            exp_q.push_back(r);
            w = 0;
            while (exp_q.size() < 64) begin
                r     = blank(iop);
                r.adr = 1'b1;
                r.mw  = !ifn[0];
                if (rdy[exp_q.size()]) begin
                    exp_q.push_back(r);
                    if (ifn[0]) begin
                        r     = blank(iop);
                        r.res = 2'b01;
                        r.rw  = 1'b1;
                        r.pcw = (ird == 4'd15);
                        exp_q.push_back(r);
                    end
                    break;
                end
                if (w == WAIT_MAX) begin
                    r.mw = 1'b0;
                    r.to = 1'b1;
                    exp_q.push_back(r);
                    break;
                end
                w++;
                exp_q.push_back(r);
            end
        end
    endtask

    // Entered and left at a falling edge; abort_at >= 0 asserts rst at that cycle of the instruction.
    task automatic run(input logic [3:0] ic, input logic [1:0] iop, input logic [5:0] ifn,
                       input logic [3:0] ird, input logic [3:0] ifl, input int abort_at);
        build(ic, iop, ifn, ird, ifl);
        n_instr++;
        for (int i = 0; i < exp_q.size(); i++) begin
            cond      = ic;
            op        = iop;
            funct     = ifn;
            rd        = ird;
            flags     = ifl;
            mem_ready = rdy[i];
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                chk($sformatf("rst_mid.i%0d", n_instr), 32'(obs), 32'(pc_sel(iop)));
                @(negedge clk);
                rst    = 1'b0;
                mflags = '0;
                mcount = 0;
                return;
            end
            #1;
            chk($sformatf("cyc.i%0d.c%0d", n_instr, i), 32'(obs), 32'(exp_q[i]));
            @(negedge clk);
        end
        mcount++;
`ifdef CU_RETIRE_CNT_EN
        chk($sformatf("icount.i%0d", n_instr), instr_count, mcount);
`endif
    endtask

    task automatic rdy_fill(input logic v);
        for (int i = 0; i < 64; i++) rdy[i] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] cmds[6];
        logic [3:0] rc, rcmd;
        logic [1:0] rop;
        logic [5:0] rfn;
        int         sel, mode;
        cmds = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b0001};

        rst = 1'b1; cond = 4'he; op = 2'b00; funct = '0; rd = '0; flags = '0; mem_ready = 1'b0;
        mflags = '0; mcount = 0;
        @(negedge clk);
        #1;
        chk("reset_ready0", 32'(obs), 32'(pc_sel(2'b00)));
        @(negedge clk);
        mem_ready = 1'b1; op = 2'b01;
        #1;
        chk("reset_ready1", 32'(obs), 32'(pc_sel(2'b01)));
`ifdef CU_RETIRE_CNT_EN
        chk("reset_icount", instr_count, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        rdy_fill(1'b1); run(4'he, 2'b00, 6'b001000, 4'd1, 4'b0000, -1);
        rdy_fill(1'b1); rdy[3] = 1'b0; rdy[4] = 1'b0;
        run(4'he, 2'b01, 6'b011001, 4'd2, 4'b0000, -1);
        rdy_fill(1'b1); run(4'he, 2'b00, 6'b010101, 4'd0, 4'b0100, -1);
        run(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);
        run(4'h1, 2'b00, 6'b001001, 4'd1, 4'b0000, -1);
        run(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);
        rdy_fill(1'b0); rdy[0] = 1'b1; run(4'he, 2'b01, 6'b011000, 4'd3, 4'b0000, -1);
        rdy_fill(1'b0); rdy[0] = 1'b1; rdy[5] = 1'b1; run(4'he, 2'b01, 6'b011000, 4'd3, 4'b0000, -1);
        rdy_fill(1'b0); rdy[0] = 1'b1; rdy[6] = 1'b1; run(4'he, 2'b01, 6'b011000, 4'd3, 4'b0000, -1);
        rdy_fill(1'b0); rdy[0] = 1'b1; run(4'he, 2'b01, 6'b011001, 4'd4, 4'b0000, -1);
        rdy_fill(1'b1); for (int i = 0; i < 5; i++) rdy[i] = 1'b0;
        run(4'he, 2'b00, 6'b101000, 4'd5, 4'b0000, -1);
        rdy_fill(1'b1); run(4'he, 2'b01, 6'b011001, 4'd15, 4'b0000, -1);
        run(4'he, 2'b00, 6'b100011, 4'd15, 4'b1010, -1);
        run(4'he, 2'b11, 6'b000000, 4'd0, 4'b0000, -1);
        rdy_fill(1'b0); rdy[0] = 1'b1; run(4'he, 2'b01, 6'b011000, 4'd3, 4'b0000, 4);
        rdy_fill(1'b1); run(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);

        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 9);
            rop = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            rc  = ($urandom_range(0, 1) == 1) ? 4'he : 4'($urandom_range(0, 14));
            rfn = 6'($urandom);
            if (rop == 2'b00) begin
                rcmd = cmds[$urandom_range(0, 5)];
                rfn  = {rfn[5], rcmd, rfn[0]};
            end
            mode = $urandom_range(0, 1);
            for (int i = 0; i < 64; i++) begin
                if (i >= 40) rdy[i] = 1'b1;
                else if (mode == 1) rdy[i] = ($urandom_range(0, 3) != 0);
                else rdy[i] = ($urandom_range(0, 1) == 1);
            end
            run(rc, rop, rfn, ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom),
                4'($urandom), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
